// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package cpu_mem_pkg;

   localparam int ADDR_W           = 16;
   localparam int DATA_W           = 16;
   localparam int MEM_LATENCY_DEF  = 2;
   localparam int EXT_MAX_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      CPU_RD_WAIT = 2'd1,
      CPU_RD_DONE = 2'd2,
      EXT_RD_WAIT = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_latency_timer.sv
// Loadable down-counter timing a memory read; done marks the cycle whose
// decrement reaches zero, which is the cycle the read data is valid.
module mem_latency_timer #(
   parameter int MEM_LATENCY = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic done
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(MEM_LATENCY);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter between the CPU memory stage and an
// external loader/debug port; also generates the pipeline stall.
//
// state        | meaning
// IDLE         | free; may issue one CPU or ext access this cycle
// CPU_RD_WAIT  | CPU read in flight, waiting on memory latency
// CPU_RD_DONE  | cpu_rdata valid, pipeline advances, no issue
// EXT_RD_WAIT  | ext read in flight; last cycle pulses ext_rvalid
module data_memory_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
   parameter int EXT_MAX_WAIT = EXT_MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_read_req,
   input  logic              cpu_write_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              stall_pipeline,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(EXT_MAX_WAIT + 1);

   arb_state_t        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              cpu_rd, cpu_wr, cpu_any;
   logic              ext_win, cpu_win;
   logic              timer_load, timer_done;
   logic              cpu_capture, ext_capture;

   // A simultaneous read and write request is a store; the read is dropped.
   assign cpu_wr  = cpu_write_req;
   assign cpu_rd  = cpu_read_req & ~cpu_write_req;
   assign cpu_any = cpu_rd | cpu_wr;

   mem_latency_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .done  (timer_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ext_win     = 1'b0;
      cpu_win     = 1'b0;
      timer_load  = 1'b0;
      cpu_capture = 1'b0;
      ext_capture = 1'b0;
      case (state)
         IDLE: begin
            if (ext_req && (!cpu_any || wait_cnt == WAIT_W'(EXT_MAX_WAIT))) begin
               ext_win = 1'b1;
               if (!ext_we) begin
                  timer_load = 1'b1;
                  state_nxt  = EXT_RD_WAIT;
               end
            end else if (cpu_any) begin
               cpu_win = 1'b1;
               if (cpu_rd) begin
                  timer_load = 1'b1;
                  state_nxt  = CPU_RD_WAIT;
               end
            end
         end
         CPU_RD_WAIT: begin
            if (timer_done) begin
               cpu_capture = 1'b1;
               state_nxt   = CPU_RD_DONE;
            end
         end
         CPU_RD_DONE: state_nxt = IDLE;
         EXT_RD_WAIT: begin
            if (ext_rvalid) begin
               state_nxt = IDLE;
            end else if (timer_done) begin
               ext_capture = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is held.
   always_comb begin
      ext_gnt        = ext_win & ~reset;
      mem_en         = (ext_win | cpu_win) & ~reset;
      mem_we         = mem_en & (ext_win ? ext_we : cpu_wr);
      mem_addr       = '0;
      mem_wdata      = '0;
      if (mem_en) begin
         mem_addr  = ext_win ? ext_addr  : cpu_addr;
         mem_wdata = ext_win ? ext_wdata : cpu_wdata;
      end
      stall_pipeline = ~reset & cpu_any &
                       ((cpu_rd & (state != CPU_RD_DONE)) | ext_win | (state == EXT_RD_WAIT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt   <= '0;
         cpu_rdata  <= '0;
         ext_rdata  <= '0;
         ext_rvalid <= 1'b0;
      end else begin
         ext_rvalid <= ext_capture;
         if (cpu_capture) cpu_rdata <= mem_rdata;
         if (ext_capture) ext_rdata <= mem_rdata;
         if (ext_gnt) begin
            wait_cnt <= '0;
         end else if (ext_req && wait_cnt != WAIT_W'(EXT_MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

endmodule
